// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port on-chip RAM.
package ram_pkg;

   typedef enum logic [0:0] {
      READ_FIRST,
      WRITE_FIRST
   } coll_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      READY
   } ram_state_e;

   localparam int unsigned MAX_DATA_WIDTH = 1024;

   // Replace the bits of old_word selected by bit_en with those of new_word.
   function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_DATA_WIDTH-1:0] bit_en
   );
      return (old_word & ~bit_en) | (new_word & bit_en);
   endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read-latency pipeline for one read port: data/valid/collision shift register.
// Each stage only loads data when a valid word enters, so the last stage holds dout between reads.
module ram_read_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  coll_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  coll_o
);

   logic [LATENCY-1:0]    valid_q, valid_d;
   logic [LATENCY-1:0]    coll_q, coll_d;
   logic [DATA_WIDTH-1:0] data_q [LATENCY];
   logic [DATA_WIDTH-1:0] data_d [LATENCY];

   always_comb begin
      valid_d   = '0;
      coll_d    = '0;
      valid_d[0] = valid_i;
      coll_d[0]  = coll_i & valid_i;
      data_d[0]  = valid_i ? data_i : data_q[0];
      for (int i = 1; i < LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         coll_d[i]  = coll_q[i-1];
         data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
      end
   end

   // Reset flushes every in-flight read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         coll_q  <= '0;
         for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         coll_q  <= coll_d;
         for (int i = 0; i < LATENCY; i++) data_q[i] <= data_d[i];
      end
   end

   assign valid_o = valid_q[LATENCY-1];
   assign coll_o  = coll_q[LATENCY-1];
   assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/ram_multi_port.sv
// Single-clock SRAM model: one RW port plus NUM_RD_PORTS read-only ports, with
// post-reset fill, configurable read latency, collision policy and range checking.
module ram_multi_port
   import ram_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH    = 32,
   parameter int unsigned            WRITE_SIZE    = 8,
   parameter int unsigned            DEPTH         = 256,
   parameter int unsigned            NUM_RD_PORTS  = 1,
   parameter int unsigned            RD_LATENCY    = 1,
   parameter coll_mode_e             COLL_MODE     = READ_FIRST,
   parameter bit                     INIT_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0]  INIT_VALUE    = '0,
   localparam int unsigned           NUM_WMASKS    = DATA_WIDTH / WRITE_SIZE,
   localparam int unsigned           ADDR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                csb0,
   input  logic                                web0,
   input  logic [NUM_WMASKS-1:0]               wmask0,
   input  logic [ADDR_WIDTH-1:0]               addr0,
   input  logic [DATA_WIDTH-1:0]               din0,
   output logic [DATA_WIDTH-1:0]               dout0,
   output logic                                rvalid0,
   input  logic [NUM_RD_PORTS-1:0]             csb_r,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]  addr_r,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]  dout_r,
   output logic [NUM_RD_PORTS-1:0]             rvalid_r,
   output logic                                ready,
   output logic [NUM_RD_PORTS:0]               coll,
   output logic                                addr_err
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   ram_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                  ready_q, ready_d;
   logic                  addr_err_q, addr_err_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_req, rd0_req, addr0_ok;
   logic [DATA_WIDTH-1:0] wr_old, wr_word, wr_bit_en, rd0_data;
   logic [NUM_RD_PORTS-1:0] rd_oob;

   // Init sequencer: one word per cycle, then accept requests.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      ready_d    = ready_q;
      case (state_q)
         INIT: begin
            ready_d    = 1'b0;
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == LAST_ADDR) begin
               state_d    = READY;
               ready_d    = 1'b1;
               init_cnt_d = '0;
            end
         end
         READY:   ready_d = 1'b1;
         default: ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT_ON_RESET ? INIT : READY;
         init_cnt_q <= '0;
         ready_q    <= !INIT_ON_RESET;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         ready_q    <= ready_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign ready    = ready_q;
   assign addr_err = addr_err_q;

   // Port 0 request decode and lane-masked write word.
   assign wr_req   = ready_q & ~csb0 & ~web0;
   assign rd0_req  = ready_q & ~csb0 & web0;
   assign addr0_ok = 32'(addr0) < DEPTH;
   assign wr_old   = addr0_ok ? mem[addr0] : '0;
   assign rd0_data = addr0_ok ? mem[addr0] : '0;

   always_comb begin
      wr_bit_en = '0;
      for (int l = 0; l < NUM_WMASKS; l++) begin
         wr_bit_en[l*WRITE_SIZE +: WRITE_SIZE] = {WRITE_SIZE{wmask0[l]}};
      end
   end

   assign wr_word = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(wr_old),
                                           MAX_DATA_WIDTH'(din0),
                                           MAX_DATA_WIDTH'(wr_bit_en)));

   // Storage is not reset; the init sequencer owns it until ready.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem[init_cnt_q] <= INIT_VALUE;
      end else if (wr_req && addr0_ok) begin
         mem[addr0] <= wr_word;
      end
   end

   assign addr_err_d = (ready_q & ~csb0 & ~addr0_ok) | (|rd_oob);

   ram_read_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (RD_LATENCY)
   ) u_pipe0 (
      .clk     (clk),
      .rst     (rst),
      .valid_i (rd0_req),
      .data_i  (rd0_data),
      .coll_i  (1'b0),
      .valid_o (rvalid0),
      .data_o  (dout0),
      .coll_o  (coll[0])
   );

   for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr_k;
      logic                  req_k, ok_k, hit_k;
      logic [DATA_WIDTH-1:0] old_k, data_k;

      assign addr_k = addr_r[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_k  = ready_q & ~csb_r[k];
      assign ok_k   = 32'(addr_k) < DEPTH;
      assign old_k  = ok_k ? mem[addr_k] : '0;
      assign hit_k  = req_k & wr_req & (addr_k == addr0);
      // wr_word is built from the same old word, so it is the write-first view.
      assign data_k = (COLL_MODE == WRITE_FIRST && hit_k && ok_k) ? wr_word : old_k;
      assign rd_oob[k] = req_k & ~ok_k;

      ram_read_pipe #(
         .DATA_WIDTH (DATA_WIDTH),
         .LATENCY    (RD_LATENCY)
      ) u_pipe (
         .clk     (clk),
         .rst     (rst),
         .valid_i (req_k),
         .data_i  (data_k),
         .coll_i  (hit_k),
         .valid_o (rvalid_r[k]),
         .data_o  (dout_r[k*DATA_WIDTH +: DATA_WIDTH]),
         .coll_o  (coll[k+1])
      );
   end

endmodule

// File: tb/tb_ram_multi_port.sv
// Directed bench: two RAM instances (READ_FIRST/latency 1 and WRITE_FIRST/latency 3) on shared stimulus.
module tb_ram_multi_port;
   import ram_pkg::*;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 200;
   localparam int unsigned NRD   = 2;
   localparam int unsigned AW    = 8;
   localparam int unsigned NM    = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            csb0, web0;
   logic [NM-1:0]   wmask0;
   logic [AW-1:0]   addr0;
   logic [DW-1:0]   din0;
   logic [NRD-1:0]  csb_r;
   logic [NRD*AW-1:0] addr_r;

   logic [DW-1:0]     a_dout0, b_dout0;
   logic              a_rvalid0, b_rvalid0;
   logic [NRD*DW-1:0] a_dout_r, b_dout_r;
   logic [NRD-1:0]    a_rvalid_r, b_rvalid_r;
   logic              a_ready, b_ready, a_addr_err, b_addr_err;
   logic [NRD:0]      a_coll, b_coll;

   logic [DW-1:0] model [DEPTH];
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   ram_multi_port #(
      .DATA_WIDTH(DW), .WRITE_SIZE(8), .DEPTH(DEPTH), .NUM_RD_PORTS(NRD), .RD_LATENCY(1),
      .COLL_MODE(READ_FIRST), .INIT_ON_RESET(1'b1), .INIT_VALUE('0)
   ) u_a (
      .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(a_dout0), .rvalid0(a_rvalid0), .csb_r(csb_r), .addr_r(addr_r), .dout_r(a_dout_r),
      .rvalid_r(a_rvalid_r), .ready(a_ready), .coll(a_coll), .addr_err(a_addr_err)
   );

   ram_multi_port #(
      .DATA_WIDTH(DW), .WRITE_SIZE(8), .DEPTH(DEPTH), .NUM_RD_PORTS(NRD), .RD_LATENCY(3),
      .COLL_MODE(WRITE_FIRST), .INIT_ON_RESET(1'b1), .INIT_VALUE('0)
   ) u_b (
      .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(b_dout0), .rvalid0(b_rvalid0), .csb_r(csb_r), .addr_r(addr_r), .dout_r(b_dout_r),
      .rvalid_r(b_rvalid_r), .ready(b_ready), .coll(b_coll), .addr_err(b_addr_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
      csb_r = '1; addr_r = '0;
   endtask

   task automatic model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m);
      if (32'(a) < DEPTH) begin
         for (int l = 0; l < NM; l++) begin
            if (m[l]) model[a][l*8 +: 8] = d[l*8 +: 8];
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m);
      csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
      step();
      csb0 = 1'b1; web0 = 1'b1;
      model_wr(a, d, m);
   endtask

   // Read one address on port 0 and both read ports; check both instances at their latency.
   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      csb0 = 1'b0; web0 = 1'b1; addr0 = a; csb_r = '0; addr_r = {a, a};
      step();
      csb0 = 1'b1; csb_r = '1;
      check({tag, "_a0"}, a_dout0, exp);
      check({tag, "_a1"}, a_dout_r[DW-1:0], exp);
      check({tag, "_a2"}, a_dout_r[2*DW-1:DW], exp);
      check({tag, "_aflags"}, 32'({a_rvalid0, a_rvalid_r, a_coll}), 32'b111_000);
      step();
      check({tag, "_apulse"}, 32'({a_rvalid0, a_rvalid_r}), 32'd0);
      check({tag, "_ahold"}, a_dout0, exp);
      step();
      check({tag, "_b0"}, b_dout0, exp);
      check({tag, "_b2"}, b_dout_r[2*DW-1:DW], exp);
      check({tag, "_bflags"}, 32'({b_rvalid0, b_rvalid_r, b_coll}), 32'b111_000);
      step();
   endtask

   // Port 0 write and read port 0 to the same address in one cycle.
   task automatic coll_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [NM-1:0] m, input logic [DW-1:0] exp_rf, input logic [DW-1:0] exp_wf);
      csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
      csb_r = '0; addr_r = {a + 8'd1, a};
      step();
      csb0 = 1'b1; web0 = 1'b1; csb_r = '1;
      model_wr(a, d, m);
      check({tag, "_rf"}, a_dout_r[DW-1:0], exp_rf);
      check({tag, "_rfflags"}, 32'({a_rvalid_r, a_coll}), 32'b11_010);
      check({tag, "_bearly"}, 32'({b_rvalid_r, b_coll}), 32'd0);
      step();
      check({tag, "_rfdrop"}, 32'(a_coll), 32'd0);
      step();
      check({tag, "_wf"}, b_dout_r[DW-1:0], exp_wf);
      check({tag, "_wfflags"}, 32'({b_rvalid_r, b_coll}), 32'b11_010);
      step();
   endtask

   // Pipelined read of every word on port 0, compared against the model.
   task automatic scan(input string tag);
      int unsigned bad_a = 0, bad_b = 0;
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         csb0 = (i >= int'(DEPTH)); web0 = 1'b1;
         addr0 = (i < int'(DEPTH)) ? AW'(i) : '0;
         step();
         if (i < int'(DEPTH)) begin
            if (!a_rvalid0 || a_dout0 !== model[i]) bad_a++;
         end else if (a_rvalid0) bad_a++;
         if (i >= 2) begin
            if (!b_rvalid0 || b_dout0 !== model[i-2]) bad_b++;
         end else if (b_rvalid0) bad_b++;
      end
      csb0 = 1'b1;
      check({tag, "_a_bad"}, bad_a, 32'd0);
      check({tag, "_b_bad"}, bad_b, 32'd0);
   endtask

   // Count cycles until ready; probe that requests during init are dropped.
   task automatic wait_ready(input string tag);
      int unsigned n = 0, stray = 0;
      while (!a_ready && n < 1000) begin
         if (n == 150) begin
            csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd3; din0 = 32'h5555_5555; wmask0 = '1;
         end else if (n == 151) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd3; csb_r = '0;
         end else begin
            csb0 = 1'b1; web0 = 1'b1; csb_r = '1;
         end
         step();
         n++;
         if (a_rvalid0 || b_rvalid0 || (|a_rvalid_r) || (|b_rvalid_r)) stray++;
      end
      idle_inputs();
      check({tag, "_len"}, n, 32'd200);
      check({tag, "_bready"}, 32'(b_ready), 32'd1);
      check({tag, "_stray"}, stray, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      model_clear();
      #2 rst = 1'b1;
      step();
      step();
      check("rst_ready", 32'({a_ready, b_ready}), 32'd0);
      check("rst_valid", 32'({a_rvalid0, a_rvalid_r, b_rvalid0, b_rvalid_r}), 32'd0);
      check("rst_dout", a_dout0 | b_dout0, 32'd0);
      check("rst_flags", 32'({a_coll, b_coll, a_addr_err, b_addr_err}), 32'd0);
      rst = 1'b0;
      wait_ready("init1");
      scan("zero");

      wr(8'h10, 32'hDEAD_BEEF, 4'b1111);
      wr(8'h10, 32'h0000_AA00, 4'b0010);
      rd_chk("mask", 8'h10, 32'hDEAD_AAEF);
      wr(8'h10, 32'hFFFF_FFFF, 4'b0000);
      rd_chk("nomask", 8'h10, 32'hDEAD_AAEF);

      wr(8'h20, 32'hCAFE_F00D, 4'b1111);
      coll_chk("coll_full", 8'h20, 32'h1234_5678, 4'b1111, 32'hCAFE_F00D, 32'h1234_5678);
      coll_chk("coll_part", 8'h20, 32'hFFFF_0000, 4'b1100, 32'h1234_5678, 32'hFFFF_5678);
      rd_chk("coll_after", 8'h20, 32'hFFFF_5678);

      for (int i = 0; i < 8; i++) wr(AW'(i), 32'h100 + 32'(i), 4'b1111);
      for (int t = 0; t < 12; t++) begin
         csb0 = (t >= 8); web0 = 1'b1; addr0 = AW'(t);
         step();
         check($sformatf("lat3_v%0d", t), 32'(b_rvalid0), 32'((t >= 2) && (t <= 9)));
         if (t >= 2 && t <= 9) check($sformatf("lat3_d%0d", t), b_dout0, 32'h100 + 32'(t - 2));
      end
      csb0 = 1'b1;

      csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd210;
      step();
      csb0 = 1'b1;
      check("oob_a_dout", a_dout0, 32'd0);
      check("oob_a_flags", 32'({a_rvalid0, a_addr_err, b_addr_err}), 32'b111);
      step();
      check("oob_err_pulse", 32'({a_addr_err, b_addr_err}), 32'd0);
      step();
      check("oob_b_dout", b_dout0, 32'd0);
      check("oob_b_valid", 32'(b_rvalid0), 32'd1);
      step();
      wr(8'd210, 32'hFFFF_FFFF, 4'b1111);
      check("oob_wr_err", 32'({a_addr_err, b_addr_err}), 32'b11);
      step();
      scan("post_oob");

      csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd5;
      step();
      addr0 = 8'd6;
      step();
      csb0 = 1'b1;
      rst = 1'b1;
      #1;
      check("flush_async", 32'({b_rvalid0, b_ready, a_ready}), 32'd0);
      step();
      check("flush_c1", 32'(b_rvalid0), 32'd0);
      step();
      check("flush_c2", 32'(b_rvalid0), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) step();
      check("mid_init_ready", 32'({a_ready, b_ready}), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_ready("init2");
      model_clear();
      scan("reinit");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
